// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
// Optional feature macro used by this slice: LSU_MISALIGN_EN.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC0 = 2'd1,
    S_ACC1 = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       ok;
    logic [2:0] nbytes;
  } size_dec_t;

  function automatic size_dec_t size_decode(input logic [2:0] f3);
    size_dec_t s;
    s.ok = 1'b1;
    case (f3)
      F3_B, F3_BU: s.nbytes = 3'd1;
      F3_H, F3_HU: s.nbytes = 3'd2;
      F3_W:        s.nbytes = 3'd4;
      default: begin
        s.ok     = 1'b0;
        s.nbytes = 3'd0;
      end
    endcase
    return s;
  endfunction

  // Bits [3:0] cover the first word, bits [7:4] the following word.
  function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [2:0] nbytes);
    logic [7:0] m;
    m = (8'h01 << nbytes) - 8'h01;
    return m << off;
  endfunction

  function automatic logic misaligned(input logic [1:0] off, input logic [2:0] nbytes);
    return ({1'b0, off} + nbytes) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data steering: store shift/lane split over two words,
// load right-shift and sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [31:0] st_lo_o,
  output logic [31:0] st_hi_o,
  output logic [3:0]  be_lo_o,
  output logic [3:0]  be_hi_o,
  output logic [31:0] ld_o
);

  size_dec_t   sz;
  logic [63:0] st_w;
  logic [63:0] ld_w;
  logic [7:0]  mask;
  logic        unused_ok;

  always_comb begin
    sz   = size_decode(funct3_i);
    st_w = {32'h0, wdata_i} << {off_i, 3'b000};
    mask = lane_mask(off_i, sz.nbytes);
    ld_w = {hi_i, lo_i} >> {off_i, 3'b000};
    case (funct3_i)
      F3_B:    ld_o = {{24{ld_w[7]}}, ld_w[7:0]};
      F3_H:    ld_o = {{16{ld_w[15]}}, ld_w[15:0]};
      F3_BU:   ld_o = {24'h0, ld_w[7:0]};
      F3_HU:   ld_o = {16'h0, ld_w[15:0]};
      default: ld_o = ld_w[31:0];
    endcase
  end

  assign st_lo_o   = st_w[31:0];
  assign st_hi_o   = st_w[63:32];
  assign be_lo_o   = mask[3:0];
  assign be_hi_o   = mask[7:4];
  assign unused_ok = ^{sz.ok, ld_w[63:32]};

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding initiator on the data-memory port.
// Define LSU_MISALIGN_EN to split misaligned H/W accesses into two word cycles.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  state_e      state_q, state_d;
  logic        we_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, lo_q, hi_val;
  size_dec_t   req_sz, cur_sz;
  logic        req_mis, req_err, cur_mis, accept;
  logic [31:0] st_lo, st_hi, ld_word, base_addr;
  logic [3:0]  be_lo, be_hi;
  logic        unused_ok;

  assign accept    = req_valid && req_ready;
  assign req_sz    = size_decode(req_funct3);
  assign req_mis   = misaligned(req_addr[1:0], req_sz.nbytes);
  assign cur_sz    = size_decode(f3_q);
  assign cur_mis   = misaligned(addr_q[1:0], cur_sz.nbytes);
  assign base_addr = {addr_q[31:2], 2'b00};

`ifdef LSU_MISALIGN_EN
  logic [31:0] hi_q;

  assign req_err   = !req_sz.ok;
  assign hi_val    = cur_mis ? hi_q : 32'h0;
  assign unused_ok = ^{cur_sz.ok, req_mis};

  always_ff @(posedge clk) begin
    if (!reset)                hi_q <= 32'h0;
    else if (state_q == S_ACC1) hi_q <= drdata;
  end
`else
  assign req_err   = !req_sz.ok || req_mis;
  assign hi_val    = 32'h0;
  assign unused_ok = ^{cur_sz.ok, cur_mis, st_hi, be_hi};
`endif

  lsu_align u_align (
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .wdata_i  (wdata_q),
    .lo_i     (lo_q),
    .hi_i     (hi_val),
    .st_lo_o  (st_lo),
    .st_hi_o  (st_hi),
    .be_lo_o  (be_lo),
    .be_hi_o  (be_hi),
    .ld_o     (ld_word)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    daddr      = 32'h0;
    dwdata     = 32'h0;
    dwe        = 4'h0;
    case (state_q)
      S_IDLE: begin
        req_ready = reset;
        if (req_valid && reset) state_d = req_err ? S_RESP : S_ACC0;
      end
      S_ACC0: begin
        daddr  = base_addr;
        dwdata = st_lo;
        dwe    = we_q ? be_lo : 4'h0;
`ifdef LSU_MISALIGN_EN
        state_d = cur_mis ? S_ACC1 : S_RESP;
`else
        state_d = S_RESP;
`endif
      end
`ifdef LSU_MISALIGN_EN
      S_ACC1: begin
        daddr   = base_addr + 32'd4;  // wraps past the top of memory
        dwdata  = st_hi;
        dwe     = we_q ? be_hi : 4'h0;
        state_d = S_RESP;
      end
`endif
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        err_q   <= req_err;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == S_ACC0) lo_q <= drdata;
    end
  end

  // Stores and errors report zero data.
  assign resp_rdata = (resp_valid && !err_q && !we_q) ? ld_word : 32'h0;
  assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a byte-array memory model.
module tb_lsu;

`ifdef LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;

  int n_chk = 0;
  int n_err = 0;

  // Memory aliases every 256 bytes; the model uses the same byte view.
  logic [31:0] mem  [0:63]  = '{default: 32'h0};
  logic [7:0]  refm [0:255] = '{default: 8'h0};

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
  );

  assign drdata = mem[daddr[7:2]];

  always @(posedge clk)
    for (int l = 0; l < 4; l++)
      if (dwe[l]) mem[daddr[7:2]][8*l +: 8] <= dwdata[8*l +: 8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd);
    int sz, o, lat, lat_exp, wcyc, exp_w, t, bi;
    bit mis, err;
    logic [7:0]  em, ba;
    logic [31:0] raw, exp_rd;
    sz  = nbytes_of(f3);
    o   = int'(addr[1:0]);
    mis = (o + sz > 4);
    err = (sz == 0) || (mis && !MIS_EN);
    em  = 8'h0;
    raw = 32'h0;
    for (int i = 0; i < sz; i++) begin
      em[o+i] = 1'b1;
      ba = addr[7:0] + 8'(i);
      raw[8*i +: 8] = refm[ba];
    end
    case (f3)
      3'b000:  exp_rd = {{24{raw[7]}}, raw[7:0]};
      3'b001:  exp_rd = {{16{raw[15]}}, raw[15:0]};
      default: exp_rd = raw;
    endcase
    if (we || err) exp_rd = 32'h0;
    lat_exp = err ? 1 : (mis ? 3 : 2);
    exp_w   = (we && !err) ? (mis ? 2 : 1) : 0;

    @(negedge clk);
    chk("ready_idle", {31'h0, req_ready}, 32'h1);
    t = 0;
    while (!req_ready && t < 8) begin @(negedge clk); t++; end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    lat = 0; wcyc = 0; rd = 32'h0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1 && !err) chk("daddr_acc0", daddr, {addr[31:2], 2'b00});
      if (c == 2 && mis && !err) chk("daddr_acc1", daddr, {addr[31:2], 2'b00} + 32'd4);
      if (dwe != 4'h0) begin
        wcyc++;
        chk("dwe", {28'h0, dwe}, (we && !err && c <= 2) ? {28'h0, em[4*(c-1) +: 4]} : 32'h0);
        for (int l = 0; l < 4; l++)
          if (dwe[l]) begin
            bi = 4*(c-1) + l - o;
            chk("dwdata_byte", {24'h0, dwdata[8*l +: 8]},
                (bi >= 0 && bi < 4) ? {24'h0, wd[8*bi +: 8]} : 32'hFFFF_FFFF);
          end
      end
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        chk("rdata", resp_rdata, exp_rd);
        chk("err", {31'h0, resp_err}, {31'h0, err});
        chk("daddr_resp", daddr, 32'h0);
        break;
      end
    end
    chk("latency", lat, lat_exp);
    chk("wr_cycles", wcyc, exp_w);

    if (we && !err)
      for (int i = 0; i < sz; i++) begin
        ba = addr[7:0] + 8'(i);
        refm[ba] = wd[8*i +: 8];
      end
  endtask

  // Misaligned (or aligned, without splitting) store cut off by reset in ACC0.
  task automatic rst_abort();
    logic [31:0] a, wd;
    logic [7:0]  ba;
    a  = MIS_EN ? 32'h46 : 32'h44;
    wd = 32'hCAFE_F00D;
    @(negedge clk);
    chk("ready_pre_rst", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("acc0_dwe_rst", {28'h0, dwe}, MIS_EN ? 32'hC : 32'hF);
    for (int i = 0; i < 4 - int'(a[1:0]); i++) begin
      ba = a[7:0] + 8'(i);
      refm[ba] = wd[8*i +: 8];
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_dwe", {28'h0, dwe}, 32'h0);
      chk("rst_resp", {31'h0, resp_valid}, 32'h0);
      chk("rst_ready", {31'h0, req_ready}, 32'h0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, req_ready}, 32'h1);
    chk("resp_after_rst", {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, addr;
    logic [2:0]  f3;
    logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", {31'h0, req_ready}, 32'h0);
    chk("rst_resp0", {31'h0, resp_valid}, 32'h0);
    chk("rst_dwe0", {28'h0, dwe}, 32'h0);
    chk("rst_daddr0", daddr, 32'h0);
    chk("rst_rdata0", resp_rdata, 32'h0);
    reset = 1'b1;

    do_req(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, rd);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, rd);
    chk("lw_100", rd, 32'hDEAD_BEEF);
    do_req(1'b1, 3'b000, 32'h203, 32'h0000_00A5, rd);
    do_req(1'b0, 3'b100, 32'h203, 32'h0, rd);
    chk("lbu_203", rd, 32'h0000_00A5);
    do_req(1'b0, 3'b000, 32'h203, 32'h0, rd);
    chk("lb_203", rd, 32'hFFFF_FFA5);
    do_req(1'b1, 3'b010, 32'h100, 32'h8001_0000, rd);
    do_req(1'b0, 3'b001, 32'h102, 32'h0, rd);
    chk("lh_102", rd, 32'hFFFF_8001);
    do_req(1'b0, 3'b101, 32'h102, 32'h0, rd);
    chk("lhu_102", rd, 32'h0000_8001);
    do_req(1'b1, 3'b010, 32'h105, 32'h1122_3344, rd);
    do_req(1'b0, 3'b010, 32'h105, 32'h0, rd);
    chk("lw_105", rd, MIS_EN ? 32'h1122_3344 : 32'h0);
    do_req(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, rd);
    do_req(1'b1, 3'b001, 32'hFFFF_FFFF, 32'hBEEF, rd);
    do_req(1'b0, 3'b011, 32'h40, 32'h0, rd);
    do_req(1'b1, 3'b111, 32'h40, 32'h1234_5678, rd);

    rst_abort();
    do_req(1'b0, 3'b010, 32'h44, 32'h0, rd);
    do_req(1'b0, 3'b010, 32'h48, 32'h0, rd);

    for (int n = 0; n < 300; n++) begin
      addr = {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0, 8'($urandom)};
      f3   = ($urandom_range(0, 9) == 0) ? 3'($urandom) : f3s[$urandom_range(0, 4)];
      do_req(1'($urandom), f3, addr, $urandom, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
